// File: rtl/adder_seq_ctrl.sv
// Sequencer and display controller for the 7-bit adder lab: one button steps A -> B -> SHOW.
// Optional macro BTN_DEBOUNCE_EN enables the button debouncer; without it every synchronized rising edge is a press.
module adder_seq_ctrl #(
    parameter int WIDTH           = 7,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_CYCLES  = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn,
    output logic [WIDTH-1:0] S,
    output logic [3:0]       an,
    output logic [7:0]       seg,
    output logic [1:0]       phase
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        SHOW   = 2'd2,
        BAD    = 2'd3
    } state_t;

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_S     = 7'b0010010;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH:0]   sum_reg;

    logic             sync1;
    logic             sync2;
    logic [1:0]       sync_fill;
    logic             armed;
    logic             level_d;
    logic             btn_level;
    logic             press;

    logic [RW-1:0]    refresh_cnt;
    logic [1:0]       digit_idx;
    logic [7:0]       disp_val;
    logic [6:0]       seg7;
    logic             dp_n;

    // armed stays low until the synchronizer has seen the button released,
    // so a button held through reset cannot generate a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_fill <= 2'd0;
            armed     <= 1'b0;
            level_d   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= btn_level;
            if (sync_fill != 2'd2)
                sync_fill <= sync_fill + 2'd1;
            if (sync_fill == 2'd2 && !sync2)
                armed <= 1'b1;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DW-1:0] db_cnt;
    logic          db_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync2 != db_level) begin
            if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign btn_level = db_level;
`else
    logic unused_db_cycles;
    assign unused_db_cycles = (DEBOUNCE_CYCLES > 0);
    assign btn_level = sync2;
`endif

    // press is a one-cycle strobe on the rising edge of the (debounced) level.
    assign press = btn_level & ~level_d & armed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= LOAD_A;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (press) begin
                        a_reg <= sw;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        b_reg   <= sw;
                        sum_reg <= {1'b0, a_reg} + {1'b0, sw};
                        state   <= SHOW;
                    end
                end
                SHOW: begin
                    if (press)
                        state <= LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    // b_reg is kept as a probe point for the operand latched in LOAD_B.
    logic unused_b_reg;
    assign unused_b_reg = ^b_reg;

    assign phase = state;

    always_comb begin
        S = sw;
        if (state == SHOW)
            S = sum_reg[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == RW'(REFRESH_CYCLES - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Anodes and cathodes both decode from the registered index, so they switch together.
    always_comb begin
        disp_val = 8'({1'b0, sw});
        if (state == SHOW)
            disp_val = 8'(sum_reg);
        an   = ~(4'b0001 << digit_idx);
        seg7 = SEG_BLANK;
        case (digit_idx)
            2'd0: seg7 = hex7(disp_val[3:0]);
            2'd1: seg7 = hex7(disp_val[7:4]);
            2'd2: seg7 = SEG_BLANK;
            default: begin
                case (state)
                    LOAD_A:  seg7 = SEG_A;
                    LOAD_B:  seg7 = SEG_B;
                    SHOW:    seg7 = SEG_S;
                    default: seg7 = SEG_BLANK;
                endcase
            end
        endcase
        dp_n = !(digit_idx == 2'd0 && state == SHOW && sum_reg[WIDTH]);
        seg  = {dp_n, seg7};
    end

endmodule
